// File: rtl/fifo_pkg.sv
// fifo_pkg: width helpers and parameter legality checks shared by the FIFO read-side blocks.
package fifo_pkg;
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction
   function automatic bit rd_lat_legal(input int lat);
      return lat >= 1 && lat <= 3;
   endfunction
endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: circular word buffer with head/tail pointers, occupancy count and sync clear.
module fifo_skid_buf import fifo_pkg::*; #(
   parameter int W = 4,
   parameter int DEPTH = 2,
   localparam int CW = cnt_w(DEPTH),
   localparam int PW = ptr_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head_data,
   output logic [CW-1:0] count
);
   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   // Depth need not be a power of two, so wrap on an explicit compare.
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction
   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[tail_q] = push_data;
      head_d = clr ? '0 : pop ? inc(head_q) : head_q;
      tail_d = clr ? '0 : push ? inc(tail_q) : tail_q;
      count_d = clr ? '0 : count_q + CW'(push) - CW'(pop);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '{default: '0};
         head_q <= '0;
         tail_q <= '0;
         count_q <= '0;
      end else begin
         mem_q <= mem_d;
         head_q <= head_d;
         tail_q <= tail_d;
         count_q <= count_d;
      end
   end
   assign head_data = mem_q[head_q];
   assign count = count_q;
   overflow_a: assert property (@(posedge clk) disable iff (rst) !(push && !pop && count_q == CW'(DEPTH)));
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a fixed-latency FIFO read port into a valid/ready stream.
// Reads are issued only against free buffer credit, so m_ready never reaches FIFO data combinationally.
module fifo_stream_reader import fifo_pkg::*; #(
   parameter int DATA_WIDTH = 4,
   parameter int RD_LATENCY = 1,
   parameter int BUF_DEPTH = 2,
   localparam int CW = cnt_w(BUF_DEPTH)
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   input  logic                  flush,
   output logic [CW-1:0]         buf_count
);
   logic [RD_LATENCY-1:0] pipe_q, pipe_d;
   logic pop, push;
   int occ;
   if (!rd_lat_legal(RD_LATENCY) || BUF_DEPTH < RD_LATENCY + 1) begin : g_bad_params
      $error("fifo_stream_reader: RD_LATENCY must be 1..3 and BUF_DEPTH >= RD_LATENCY+1");
   end
   always_comb begin
      pop = m_valid & m_ready;
      occ = int'(buf_count) + int'($countones(pipe_q)) - int'(pop);
      fifo_rd_en = ~fifo_empty & ~flush & ~rd_rst & (occ < BUF_DEPTH);
      pipe_d = flush ? '0 : RD_LATENCY'({pipe_q, fifo_rd_en});
      push = pipe_q[RD_LATENCY-1] & ~flush;
   end
   always_ff @(posedge rd_clk) begin
      if (rd_rst) pipe_q <= '0;
      else pipe_q <= pipe_d;
   end
   fifo_skid_buf #(.W(DATA_WIDTH), .DEPTH(BUF_DEPTH)) u_buf (
      .clk(rd_clk),
      .rst(rd_rst),
      .clr(flush),
      .push(push),
      .push_data(fifo_rd_data),
      .pop(pop),
      .head_data(m_data),
      .count(buf_count)
   );
   assign m_valid = buf_count != '0;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: two configurations (lat 1/depth 2, lat 3/depth 5) driven by shared
// control, each checked every cycle against a queue model of FIFO, in-flight reads and buffer.
module tb_fifo_stream_reader;
   localparam int N = 2;
   localparam int LAT [N] = '{1, 3};
   localparam int DEP [N] = '{2, 5};
   logic clk = 0, rst = 1, flush = 0, m_ready = 0;
   int total = 0, bad = 0;
   logic [3:0] src [$];
   int avail = 0;
   int rdp [N], dlv [N], first_rd [N], first_val [N], last_dlv [N], fidx [N], bcnt [N], lost [N];
   logic mval [N];
   logic [3:0] mdat [N];
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask
   for (genvar i = 0; i < N; i++) begin : g_inst
      localparam int L = LAT[i];
      localparam int D = DEP[i];
      localparam int CW = $clog2(D + 1);
      logic empty = 1;
      logic rd_en, valid;
      logic [3:0] rdata = 0, data;
      logic [CW-1:0] count;
      fifo_stream_reader #(.DATA_WIDTH(4), .RD_LATENCY(L), .BUF_DEPTH(D)) dut (
         .rd_clk(clk),
         .rd_rst(rst),
         .fifo_empty(empty),
         .fifo_rd_en(rd_en),
         .fifo_rd_data(rdata),
         .m_valid(valid),
         .m_data(data),
         .m_ready(m_ready),
         .flush(flush),
         .buf_count(count)
      );
      initial begin
         logic [3:0] mb [$];
         logic [3:0] inf_d [$];
         int inf_t [$];
         logic [3:0] stage [4];
         logic [3:0] word;
         logic pop, exp_rd, a_rd, s_rst, s_fl;
         int c;
         c = 0;
         stage = '{default: '0};
         forever begin
            @(negedge clk);
            pop = mb.size() != 0 && m_ready;
            exp_rd = !empty && !flush && !rst && (mb.size() + inf_d.size() - int'(pop) < D);
            chk($sformatf("i%0d_rd_en", i), int'(rd_en), int'(exp_rd));
            chk($sformatf("i%0d_m_valid", i), int'(valid), int'(mb.size() != 0));
            chk($sformatf("i%0d_buf_count", i), int'(count), mb.size());
            if (mb.size() != 0) chk($sformatf("i%0d_m_data", i), int'(data), int'(mb[0]));
            a_rd = rd_en;
            s_rst = rst;
            s_fl = flush;
            if (rd_en) begin
               rdp[i]++;
               if (first_rd[i] < 0) first_rd[i] = c;
            end
            if (valid && first_val[i] < 0) first_val[i] = c;
            if (pop) begin
               dlv[i]++;
               last_dlv[i] = c;
            end
            mval[i] = valid;
            mdat[i] = data;
            bcnt[i] = int'(count);
            @(posedge clk);
            #1;
            if (s_rst || s_fl) begin
               mb.delete();
               inf_d.delete();
               inf_t.delete();
            end else begin
               if (pop) void'(mb.pop_front());
               if (inf_t.size() != 0 && inf_t[0] + L == c) begin
                  mb.push_back(inf_d.pop_front());
                  void'(inf_t.pop_front());
               end
            end
            word = 4'($urandom);
            if (a_rd && fidx[i] < avail) begin
               word = src[fidx[i]];
               fidx[i]++;
            end
            if (a_rd && !s_rst && !s_fl) begin
               inf_d.push_back(word);
               inf_t.push_back(c);
            end
            for (int k = L; k > 1; k--) stage[k] = stage[k-1];
            stage[1] = word;
            rdata = stage[L];
            empty = fidx[i] >= avail;
            c++;
         end
      end
   end
   initial begin
      for (int k = 0; k < N; k++) begin
         rdp[k] = 0; dlv[k] = 0; first_rd[k] = -1; first_val[k] = -1;
         last_dlv[k] = -1; fidx[k] = 0; lost[k] = 0;
      end
      for (int k = 1; k <= 8; k++) src.push_back(4'(k));
      avail = 8;
      step(3);
      for (int k = 0; k < N; k++) begin
         chk("reset_reads", rdp[k], 0);
         chk("reset_count", bcnt[k], 0);
         chk("reset_valid", int'(mval[k]), 0);
      end
      rst = 0;
      m_ready = 1;
      step(16);
      for (int k = 0; k < N; k++) begin
         chk("first_latency", first_val[k] - first_rd[k], LAT[k] + 1);
         chk("burst_span", last_dlv[k] - first_val[k], 7);
         chk("burst_words", dlv[k], 8);
      end
      m_ready = 0;
      for (int k = 0; k < N; k++) rdp[k] = 0;
      for (int j = 0; j < 10; j++) src.push_back(4'(9 + j));
      avail += 10;
      step(12);
      for (int k = 0; k < N; k++) begin
         chk("bp_reads", rdp[k], DEP[k]);
         chk("bp_count", bcnt[k], DEP[k]);
         chk("bp_head", int'(mdat[k]), 9);
         dlv[k] = 0;
      end
      m_ready = 1;
      step(16);
      for (int k = 0; k < N; k++) chk("bp_release_words", dlv[k], 10);
      for (int k = 0; k < N; k++) begin rdp[k] = 0; dlv[k] = 0; end
      src.push_back(4'h3); src.push_back(4'h5); src.push_back(4'h7);
      avail += 3;
      step(10);
      for (int k = 0; k < N; k++) begin
         chk("empty_reads", rdp[k], 3);
         chk("empty_words", dlv[k], 3);
         chk("empty_valid", int'(mval[k]), 0);
      end
      m_ready = 0;
      for (int k = 0; k < N; k++) rdp[k] = 0;
      for (int j = 0; j < 10; j++) src.push_back(4'($urandom));
      avail += 10;
      step(2);
      flush = 1;
      step(1);
      flush = 0;
      for (int k = 0; k < N; k++) lost[k] = rdp[k];
      @(negedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         chk("flush_valid", int'(mval[k]), 0);
         chk("flush_count", bcnt[k], 0);
         chk("flush_lost_some", int'(lost[k] > 0), 1);
      end
      step(1);
      for (int k = 0; k < N; k++) dlv[k] = 0;
      m_ready = 1;
      step(20);
      for (int k = 0; k < N; k++) chk("flush_after_words", dlv[k], 10 - lost[k]);
      for (int k = 0; k < N; k++) begin dlv[k] = 0; first_val[k] = -1; end
      for (int j = 0; j < 16; j++) src.push_back(4'(j));
      avail += 16;
      step(26);
      for (int k = 0; k < N; k++) begin
         chk("stream16_span", last_dlv[k] - first_val[k], 15);
         chk("stream16_words", dlv[k], 16);
      end
      repeat (500) begin
         m_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 39) == 0);
         rst = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 2) != 0) begin
            src.push_back(4'($urandom));
            avail++;
         end
         step(1);
      end
      rst = 0;
      flush = 0;
      m_ready = 1;
      step(40);
      for (int k = 0; k < N; k++) begin
         chk("drain_fifo", fidx[k], avail);
         chk("drain_valid", int'(mval[k]), 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
